// File: rtl/fb_access_scheduler.sv
// Framebuffer single-port scheduler: scan-out reads win, then the fill engine, then queued CPU pixels.
// Optional FB_AUTOINC_EN: PIXEL writes advance the X/Y cursor with raster wrap.
module fb_access_scheduler #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [1:0]  CPU_ADDR,
  input  logic [7:0]  CPU_WDATA,
  input  logic        CPU_WR,
  input  logic        CPU_RD,
  output logic [7:0]  CPU_RDATA,
  input  logic        SCAN_REQ,
  input  logic [14:0] SCAN_ADDR,
  output logic [14:0] FB_ADDR,
  output logic        FB_WE,
  output logic [2:0]  FB_WDATA,
  output logic        BUSY
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]    X_MAX     = 8'(FB_W - 1);
  localparam logic [7:0]    Y_MAX     = 8'(FB_H - 1);
  localparam logic [14:0]   FB_W_15   = 15'(FB_W);
  localparam logic [14:0]   LAST_ADDR = 15'(FB_W * FB_H - 1);
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   CNT_ONE   = 1;

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t        state_q, state_d;
  logic [14:0]   fill_cnt_q, fill_cnt_d;
  logic [2:0]    fill_color_q, fill_color_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [17:0]   fifo_mem [FIFO_DEPTH];
  logic [17:0]   fifo_head;
  logic [14:0]   push_addr;
  logic          fifo_full, fifo_empty;
  logic          pix_wr, cmd_wr, in_range, push_acc, pop, fill_start;
  logic [14:0]   fb_addr;
  logic          fb_we;
  logic [2:0]    fb_wdata;

  assign pix_wr     = CPU_WR && (CPU_ADDR == 2'd2);
  assign cmd_wr     = CPU_WR && (CPU_ADDR == 2'd3);
  assign in_range   = (x_q <= X_MAX) && (y_q <= Y_MAX);
  assign fifo_full  = count_q[AW];
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign push_addr  = ({7'd0, y_q} * FB_W_15) + {7'd0, x_q};
  // A full FIFO still accepts a push when the same cycle pops an entry.
  assign push_acc   = pix_wr && in_range && (!fifo_full || pop);

  // State and arbitration registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      fill_cnt_q   <= '0;
      fill_color_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_color_q <= fill_color_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    fill_color_d = fill_color_q;
    fb_addr      = SCAN_ADDR;
    fb_we        = 1'b0;
    fb_wdata     = 3'd0;
    pop          = 1'b0;
    fill_start   = 1'b0;

    if (SCAN_REQ) begin
      fb_addr = SCAN_ADDR;
    end else if (state_q == S_FILL) begin
      fb_addr  = fill_cnt_q;
      fb_we    = 1'b1;
      fb_wdata = fill_color_q;
      if (fill_cnt_q == LAST_ADDR) begin
        state_d = S_IDLE;
      end else begin
        fill_cnt_d = fill_cnt_q + 15'd1;
      end
    end else if (!fifo_empty) begin
      fb_addr  = fifo_head[17:3];
      fb_wdata = fifo_head[2:0];
      fb_we    = 1'b1;
      pop      = 1'b1;
    end

    // Fill requests arriving mid-fill are ignored so the running fill finishes intact.
    if (cmd_wr && CPU_WDATA[0] && (state_q == S_IDLE)) begin
      fill_start   = 1'b1;
      state_d      = S_FILL;
      fill_cnt_d   = '0;
      fill_color_d = CPU_WDATA[3:1];
    end
  end

  // The RAM port is held quiet for as long as reset is asserted.
  assign FB_ADDR  = RESET_N ? fb_addr : 15'd0;
  assign FB_WE    = RESET_N && fb_we;
  assign FB_WDATA = fb_wdata;

  always_ff @(posedge CLK) begin
    if (push_acc) begin
      fifo_mem[wr_ptr_q] <= {push_addr, CPU_WDATA[2:0]};
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_q      <= '0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    rdata_d  = rdata_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (CPU_WR && (CPU_ADDR == 2'd0)) x_d = CPU_WDATA;
    if (CPU_WR && (CPU_ADDR == 2'd1)) y_d = CPU_WDATA;

`ifdef FB_AUTOINC_EN
    if (pix_wr && in_range) begin
      if (x_q == X_MAX) begin
        x_d = 8'd0;
        y_d = (y_q == Y_MAX) ? 8'd0 : y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
`endif

    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_acc && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push_acc) begin
      count_d = count_q - CNT_ONE;
    end

    if (pix_wr && in_range && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (cmd_wr && CPU_WDATA[7]) begin
      ovf_d = 1'b0;
    end

    if (CPU_RD) begin
      case (CPU_ADDR)
        2'd0:    rdata_d = x_q;
        2'd1:    rdata_d = y_q;
        2'd2:    rdata_d = 8'd0;
        default: rdata_d = {4'b0000, ovf_q, (state_q == S_FILL), fifo_full, fifo_empty};
      endcase
    end
  end

  // Stays high one cycle past the last pending work so software never sees a gap.
  assign busy_d    = !fifo_empty || (state_q == S_FILL) || push_acc || fill_start;
  assign BUSY      = busy_q;
  assign CPU_RDATA = rdata_q;

endmodule

// File: doc/fb_access_scheduler.md
Name: fb_access_scheduler

Overview:
Schedules every access to the 160x120, 3-bit framebuffer RAM, sharing its single port between the video scan-out reader and the 6502 bus.
- Scan-out has absolute priority.
- CPU pixel writes are buffered in a FIFO and drained in idle cycles.
- A hardware fill engine clears or fills the whole screen in idle cycles.
- Sits between the 6502 bus-decode logic (already synchronised to CLK) and the framebuffer RAM/VGA timing block.

Parameters:
FB_W, 160, framebuffer width in pixels
FB_H, 120, framebuffer height in pixels
FIFO_DEPTH, 8, CPU write FIFO entries (power of 2)

Ports:
CLK  in  1  system clock (50 MHz)
RESET_N  in  1  asynchronous active-low reset
CPU_ADDR  in  2  register select
CPU_WDATA  in  8  CPU write data
CPU_WR  in  1  one-cycle write strobe
CPU_RD  in  1  one-cycle read strobe
CPU_RDATA  out  8  registered read data
SCAN_REQ  in  1  scan-out read request, this cycle
SCAN_ADDR  in  15  scan-out linear address
FB_ADDR  out  15  RAM address
FB_WE  out  1  RAM write enable
FB_WDATA  out  3  RAM write data (bit0 R, bit1 G, bit2 B)
BUSY  out  1  FIFO non-empty or fill active

Behaviour:
Interface decisions:
- One clock, CLK.
- Reset RESET_N is asynchronous and active-low.

Register map, CPU_ADDR:
- 0: X, read/write, 8 bits.
- 1: Y, read/write, 8 bits.
- 2: PIXEL. A write pushes {addr=Y*FB_W+X, color=CPU_WDATA[2:0]}. Reads return 0.
- 3 write: CMD.
  - bit0=1 starts a fill with color CPU_WDATA[3:1].
  - bit7=1 clears OVF.
- 3 read: STATUS = {4'b0, OVF, FILL_BUSY, FIFO_FULL, FIFO_EMPTY}.

Register and reset rules:
- CPU_RDATA updates on the CLK edge after CPU_RD and holds until the next read.
- Reset values: X=Y=0, FIFO empty, OVF=0, FSM=IDLE, CPU_RDATA=0, BUSY=0.
- FB_WE=0 and FB_ADDR=0 while in reset.
- Reset mid-fill or with a non-empty FIFO aborts and discards all pending work.

PIXEL push rules:
- If X>=FB_W or Y>=FB_H, the push is dropped silently and OVF is unchanged.
- If the FIFO is full and no pop occurs in the same cycle, the push is dropped and OVF=1 (sticky).
- A push and a pop in the same cycle are both honoured, so the count is unchanged.
- The address multiply is done at push time; the FIFO stores 15-bit addr + 3-bit color.

Port arbitration (combinational, per cycle):
- SCAN_REQ=1: FB_ADDR=SCAN_ADDR, FB_WE=0. No other progress.
- Else if FSM=FILL: FB_ADDR=fill_cnt, FB_WE=1, FB_WDATA=fill_color, fill_cnt++.
- Else if FIFO non-empty: FB_ADDR/FB_WDATA=FIFO head, FB_WE=1, pop.
- Else: FB_WE=0, FB_ADDR=SCAN_ADDR.

FSM:
- IDLE -> FILL on a CMD write with bit0=1; fill_cnt=0 and fill_color is latched.
- FILL -> IDLE on the cycle that writes address FB_W*FB_H-1 (19199 at defaults).
- A CMD fill request while in FILL is ignored; the original fill continues.
- PIXEL pushes during FILL are accepted into the FIFO and drain only after the fill completes. Pixels written after a fill command therefore always land on top of the fill.

BUSY is registered: 1 the cycle after any push or fill start, 0 the cycle after FIFO empty and FSM=IDLE.

Optional Feature:
FB_AUTOINC_EN
- Defined: every accepted or in-range PIXEL write increments X.
  - At X=FB_W-1, X wraps to 0 and Y increments.
  - At Y=FB_H-1 with X=FB_W-1, both wrap to 0.
  - An out-of-range push leaves X/Y unchanged.
- Undefined: X/Y change only on explicit writes to registers 0/1.

Test Plan:
- Reset state: assert RESET_N=0 mid-fill at fill_cnt=500 -> next cycle FB_WE=0, STATUS reads 0x01, no further RAM writes after release.
- Single pixel: X=10, Y=20, PIXEL=0x05 with SCAN_REQ=0 -> within 2 cycles FB_WE=1, FB_ADDR=3210, FB_WDATA=3'b101; STATUS returns to 0x01.
- Scan priority: hold SCAN_REQ=1 for 50 cycles with 3 pixels queued -> FB_WE=0 and FB_ADDR=SCAN_ADDR throughout; the 3 writes appear in push order in the 3 cycles after SCAN_REQ drops.
- Overflow: SCAN_REQ=1, push 9 pixels -> STATUS=0x0A (FULL, OVF), exactly 8 writes after release; CMD=0x80 clears OVF.
- Fill: CMD=0x0B (color 3'b101) with SCAN_REQ toggling 50% -> 19200 writes covering 0..19199 exactly once, FILL_BUSY clears, BUSY=0; a pixel pushed mid-fill is written after address 19199.
- Autoinc (FB_AUTOINC_EN): X=159, Y=119, two PIXEL writes -> addresses 19199 then 0; X=1, Y=0 afterwards. Without the macro: both writes go to 19199.
